// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RV32I main control FSM
//
// Purpose: sequences each instruction through fetch, decode, execute,
// memory and writeback, driving datapath enables, mux selects, the ALU
// class code and the is_immediate flag for the ALU-control decoder.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   - unknown opcode in DECODE enters HALT (illegal_o=1) until reset
//   undefined - unknown opcode returns to FETCH, illegal_o tied 0
//
// Parameter: USE_MEM_READY (1 = memory states wait on mem_ready_i,
//            0 = memory always treated as ready)
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   opcode_i[6:0]            IR[6:0]
//   zero_i                   ALU zero flag (branch taken)
//   mem_ready_i              memory access completes this cycle
//   pc_write_o, ir_write_o   PC / IR load enables
//   pc_source_o              0 = ALU result, 1 = ALUOut
//   lord_o                   memory address: 0 = PC, 1 = ALUOut
//   memory_read_o/_write_o   memory requests
//   reg_write_o              register-file write enable
//   memory_to_reg_o[1:0]     00 = ALUOut, 01 = MDR, 10 = PC
//   alu_src_a_o[1:0]         00 = PC, 01 = oldPC, 10 = regA, 11 = zero
//   alu_src_b_o[1:0]         00 = regB, 01 = 4, 10 = imm
//   alu_co_o[1:0]            00 = add, 01 = branch, 10 = ALU
//   is_immediate_o           I-type ALU operation
//   illegal_o                halted on an unknown opcode

module multicycle_control_fsm #(
   parameter bit USE_MEM_READY = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [6:0] opcode_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       ir_write_o,
   output logic       pc_source_o,
   output logic       lord_o,
   output logic       memory_read_o,
   output logic       memory_write_o,
   output logic       reg_write_o,
   output logic [1:0] memory_to_reg_o,
   output logic [1:0] alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] alu_co_o,
   output logic       is_immediate_o,
   output logic       illegal_o
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_LUI,
      S_AUIPC
`ifdef ILLEGAL_TRAP_EN
      , S_HALT
`endif
   } state_t;

   state_t state, state_next;
   logic   ready;

   // With the handshake disabled every memory access completes at once.
   assign ready = USE_MEM_READY ? mem_ready_i : 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next      = state;
      pc_write_o      = 1'b0;
      ir_write_o      = 1'b0;
      pc_source_o     = 1'b0;
      lord_o          = 1'b0;
      memory_read_o   = 1'b0;
      memory_write_o  = 1'b0;
      reg_write_o     = 1'b0;
      memory_to_reg_o = 2'b00;
      alu_src_a_o     = 2'b00;
      alu_src_b_o     = 2'b00;
      alu_co_o        = 2'b00;
      is_immediate_o  = 1'b0;
      illegal_o       = 1'b0;

      case (state)
         S_FETCH: begin
            memory_read_o = 1'b1;
            alu_src_b_o   = 2'b01;
            ir_write_o    = ready;
            pc_write_o    = ready;
            if (ready) state_next = S_DECODE;
         end
         S_DECODE: begin
            // Speculative branch/JAL target computed into ALUOut.
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
            case (opcode_i)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_R:              state_next = S_EXEC_R;
               OP_I:              state_next = S_EXEC_I;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALR;
               OP_LUI:            state_next = S_LUI;
               OP_AUIPC:          state_next = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
               default:           state_next = S_HALT;
`else
               default:           state_next = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            alu_src_a_o    = 2'b10;
            alu_src_b_o    = 2'b10;
            is_immediate_o = 1'b1;
            state_next     = (opcode_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            memory_read_o = 1'b1;
            lord_o        = 1'b1;
            if (ready) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write_o     = 1'b1;
            memory_to_reg_o = 2'b01;
            state_next      = S_FETCH;
         end
         S_MEMWRITE: begin
            memory_write_o = 1'b1;
            lord_o         = 1'b1;
            if (ready) state_next = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a_o = 2'b10;
            alu_co_o    = 2'b10;
            state_next  = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a_o    = 2'b10;
            alu_src_b_o    = 2'b10;
            alu_co_o       = 2'b10;
            is_immediate_o = 1'b1;
            state_next     = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_o = 1'b1;
            state_next  = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_o = 2'b10;
            alu_co_o    = 2'b01;
            pc_source_o = 1'b1;
            pc_write_o  = zero_i;
            state_next  = S_FETCH;
         end
         S_JAL: begin
            reg_write_o     = 1'b1;
            memory_to_reg_o = 2'b10;
            pc_write_o      = 1'b1;
            pc_source_o     = 1'b1;
            state_next      = S_FETCH;
         end
         S_JALR: begin
            alu_src_a_o     = 2'b10;
            alu_src_b_o     = 2'b10;
            is_immediate_o  = 1'b1;
            pc_write_o      = 1'b1;
            reg_write_o     = 1'b1;
            memory_to_reg_o = 2'b10;
            state_next      = S_FETCH;
         end
         S_LUI: begin
            alu_src_a_o = 2'b11;
            alu_src_b_o = 2'b10;
            state_next  = S_ALUWB;
         end
         S_AUIPC: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
            state_next  = S_ALUWB;
         end
`ifdef ILLEGAL_TRAP_EN
         S_HALT: begin
            illegal_o  = 1'b1;
            state_next = S_HALT;
         end
`endif
         default: state_next = S_FETCH;
      endcase

      // Reset silences every output so an aborted instruction writes nothing.
      if (rst_i) begin
         pc_write_o      = 1'b0;
         ir_write_o      = 1'b0;
         pc_source_o     = 1'b0;
         lord_o          = 1'b0;
         memory_read_o   = 1'b0;
         memory_write_o  = 1'b0;
         reg_write_o     = 1'b0;
         memory_to_reg_o = 2'b00;
         alu_src_a_o     = 2'b00;
         alu_src_b_o     = 2'b00;
         alu_co_o        = 2'b00;
         is_immediate_o  = 1'b0;
         illegal_o       = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm

module tb_multicycle_control_fsm;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [6:0] opcode_i = 7'b0;
   logic       zero_i = 1'b0;
   logic       mem_ready_i = 1'b0;
   logic       pc_write_o, ir_write_o, pc_source_o, lord_o;
   logic       memory_read_o, memory_write_o, reg_write_o;
   logic [1:0] memory_to_reg_o, alu_src_a_o, alu_src_b_o, alu_co_o;
   logic       is_immediate_o, illegal_o;

   int checks = 0;
   int failures = 0;

   multicycle_control_fsm dut (
      .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
      .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .ir_write_o(ir_write_o),
      .pc_source_o(pc_source_o), .lord_o(lord_o), .memory_read_o(memory_read_o),
      .memory_write_o(memory_write_o), .reg_write_o(reg_write_o),
      .memory_to_reg_o(memory_to_reg_o), .alu_src_a_o(alu_src_a_o),
      .alu_src_b_o(alu_src_b_o), .alu_co_o(alu_co_o),
      .is_immediate_o(is_immediate_o), .illegal_o(illegal_o)
   );

   always #5 clk_i = ~clk_i;

   // {pc_write, ir_write, pc_source, lord, mem_read, mem_write, reg_write,
   //  memory_to_reg, src_a, src_b, alu_co, is_immediate, illegal}
   logic [16:0] obs;
   assign obs = {pc_write_o, ir_write_o, pc_source_o, lord_o, memory_read_o,
                 memory_write_o, reg_write_o, memory_to_reg_o, alu_src_a_o,
                 alu_src_b_o, alu_co_o, is_immediate_o, illegal_o};

   function automatic logic [16:0] v(input logic pw, input logic irw, input logic ps,
                                     input logic lo, input logic mr, input logic mw,
                                     input logic rw, input logic [1:0] mtr,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] co, input logic ii, input logic il);
      return {pw, irw, ps, lo, mr, mw, rw, mtr, sa, sb, co, ii, il};
   endfunction

   typedef struct {
      logic [16:0] e;
      logic        r;
      logic [6:0]  op;
      logic        z;
   } cyc_t;

   cyc_t       q[$];
   logic [6:0] cur_op;
   logic       cur_z;

   task automatic push(input logic [16:0] e, input logic r);
      cyc_t c;
      c.e = e; c.r = r; c.op = cur_op; c.z = cur_z;
      q.push_back(c);
   endtask

   // Reference model: expected per-cycle outputs for one instruction, given
   // the number of wait cycles in fetch (wf) and in the data access (wm).
   task automatic gen_instr(input logic [6:0] op, input logic z, input int wf, input int wm);
      logic [16:0] aluwb;
      cur_op = op;
      cur_z  = z;
      aluwb  = v(0,0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, 2'd0, 0,0);
      for (int i = 0; i < wf; i++) push(v(0,0,0,0,1,0,0, 2'd0, 2'd0, 2'd1, 2'd0, 0,0), 1'b0);
      push(v(1,1,0,0,1,0,0, 2'd0, 2'd0, 2'd1, 2'd0, 0,0), 1'b1);
      push(v(0,0,0,0,0,0,0, 2'd0, 2'd1, 2'd2, 2'd0, 0,0), 1'($urandom_range(0,1)));
      case (op)
         7'b0110011: begin
            push(v(0,0,0,0,0,0,0, 2'd0, 2'd2, 2'd0, 2'd2, 0,0), 1'($urandom_range(0,1)));
            push(aluwb, 1'($urandom_range(0,1)));
         end
         7'b0010011: begin
            push(v(0,0,0,0,0,0,0, 2'd0, 2'd2, 2'd2, 2'd2, 1,0), 1'($urandom_range(0,1)));
            push(aluwb, 1'($urandom_range(0,1)));
         end
         7'b0110111: begin
            push(v(0,0,0,0,0,0,0, 2'd0, 2'd3, 2'd2, 2'd0, 0,0), 1'($urandom_range(0,1)));
            push(aluwb, 1'($urandom_range(0,1)));
         end
         7'b0010111: begin
            push(v(0,0,0,0,0,0,0, 2'd0, 2'd1, 2'd2, 2'd0, 0,0), 1'($urandom_range(0,1)));
            push(aluwb, 1'($urandom_range(0,1)));
         end
         7'b0000011: begin
            push(v(0,0,0,0,0,0,0, 2'd0, 2'd2, 2'd2, 2'd0, 1,0), 1'($urandom_range(0,1)));
            for (int i = 0; i < wm; i++) push(v(0,0,0,1,1,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,0), 1'b0);
            push(v(0,0,0,1,1,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,0), 1'b1);
            push(v(0,0,0,0,0,0,1, 2'd1, 2'd0, 2'd0, 2'd0, 0,0), 1'($urandom_range(0,1)));
         end
         7'b0100011: begin
            push(v(0,0,0,0,0,0,0, 2'd0, 2'd2, 2'd2, 2'd0, 1,0), 1'($urandom_range(0,1)));
            for (int i = 0; i < wm; i++) push(v(0,0,0,1,0,1,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,0), 1'b0);
            push(v(0,0,0,1,0,1,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,0), 1'b1);
         end
         7'b1100011: push(v(z,0,1,0,0,0,0, 2'd0, 2'd2, 2'd0, 2'd1, 0,0), 1'($urandom_range(0,1)));
         7'b1101111: push(v(1,0,1,0,0,0,1, 2'd2, 2'd0, 2'd0, 2'd0, 0,0), 1'($urandom_range(0,1)));
         7'b1100111: push(v(1,0,0,0,0,0,1, 2'd2, 2'd2, 2'd2, 2'd0, 1,0), 1'($urandom_range(0,1)));
         default: ;
      endcase
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         opcode_i = 7'($urandom); mem_ready_i = 1'($urandom_range(0,1)); zero_i = 1'b1;
         #1;
         checks++;
         if (obs !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs cyc%0d got=%b exp=%b", i, obs, 17'd0);
         end
      end
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic test_add();
      int n = 0;
      gen_instr(7'b0110011, 1'b0, 0, 0);
      while (q.size() > 0) begin
         cyc_t c = q.pop_front();
         opcode_i = c.op; zero_i = c.z; mem_ready_i = c.r; #1;
         checks++;
         if (obs !== c.e) begin
            failures++;
            $display("FAIL add cyc%0d got=%b exp=%b", n, obs, c.e);
         end
         n++;
         @(negedge clk_i);
      end
   endtask

   task automatic test_load_wait();
      int n = 0;
      gen_instr(7'b0000011, 1'b0, 0, 2);
      while (q.size() > 0) begin
         cyc_t c = q.pop_front();
         opcode_i = c.op; zero_i = c.z; mem_ready_i = c.r; #1;
         checks++;
         if (obs !== c.e) begin
            failures++;
            $display("FAIL load_wait cyc%0d got=%b exp=%b", n, obs, c.e);
         end
         n++;
         @(negedge clk_i);
      end
      checks++;
      if (n != 7) begin
         failures++;
         $display("FAIL load_latency got=%0d exp=7", n);
      end
   endtask

   task automatic test_branch();
      int n = 0;
      gen_instr(7'b1100011, 1'b1, 0, 0);
      gen_instr(7'b1100011, 1'b0, 0, 0);
      gen_instr(7'b1101111, 1'b0, 1, 0);
      while (q.size() > 0) begin
         cyc_t c = q.pop_front();
         opcode_i = c.op; zero_i = c.z; mem_ready_i = c.r; #1;
         checks++;
         if (obs !== c.e) begin
            failures++;
            $display("FAIL branch cyc%0d got=%b exp=%b", n, obs, c.e);
         end
         n++;
         @(negedge clk_i);
      end
   endtask

   task automatic test_jalr();
      int n = 0;
      gen_instr(7'b1100111, 1'b0, 0, 0);
      while (q.size() > 0) begin
         cyc_t c = q.pop_front();
         opcode_i = c.op; zero_i = c.z; mem_ready_i = c.r; #1;
         checks++;
         if (obs !== c.e) begin
            failures++;
            $display("FAIL jalr cyc%0d got=%b exp=%b", n, obs, c.e);
         end
         n++;
         @(negedge clk_i);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops [0:8];
      int n = 0;
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      for (int k = 0; k < 60; k++) begin
`ifdef ILLEGAL_TRAP_EN
         gen_instr(ops[$urandom_range(0,8)], 1'($urandom_range(0,1)),
                   $urandom_range(0,3), $urandom_range(0,3));
`else
         if ($urandom_range(0,9) == 0)
            gen_instr(7'b1111111, 1'b0, $urandom_range(0,2), 0);
         else
            gen_instr(ops[$urandom_range(0,8)], 1'($urandom_range(0,1)),
                      $urandom_range(0,3), $urandom_range(0,3));
`endif
      end
      while (q.size() > 0) begin
         cyc_t c = q.pop_front();
         opcode_i = c.op; zero_i = c.z; mem_ready_i = c.r; #1;
         checks++;
         if (obs !== c.e) begin
            failures++;
            $display("FAIL back_to_back cyc%0d op=%b got=%b exp=%b", n, c.op, obs, c.e);
         end
         n++;
         @(negedge clk_i);
      end
   endtask

   task automatic test_reset_mid_store();
      int n = 0;
      gen_instr(7'b0100011, 1'b0, 0, 2);
      void'(q.pop_back());
      while (q.size() > 0) begin
         cyc_t c = q.pop_front();
         opcode_i = c.op; zero_i = c.z; mem_ready_i = c.r; #1;
         checks++;
         if (obs !== c.e) begin
            failures++;
            $display("FAIL store_pre_reset cyc%0d got=%b exp=%b", n, obs, c.e);
         end
         n++;
         @(negedge clk_i);
      end
      rst_i = 1'b1; mem_ready_i = 1'b1; #1;
      checks++;
      if (obs !== 17'd0) begin
         failures++;
         $display("FAIL store_reset_abort got=%b exp=%b", obs, 17'd0);
      end
      @(negedge clk_i);
      rst_i = 1'b0; mem_ready_i = 1'b0; #1;
      checks++;
      if (obs !== v(0,0,0,0,1,0,0, 2'd0, 2'd0, 2'd1, 2'd0, 0,0)) begin
         failures++;
         $display("FAIL store_reset_to_fetch got=%b exp=%b", obs,
                  v(0,0,0,0,1,0,0, 2'd0, 2'd0, 2'd1, 2'd0, 0,0));
      end
      @(negedge clk_i);
   endtask

   task automatic test_illegal();
      int n = 0;
      gen_instr(7'b1111111, 1'b0, 0, 0);
`ifndef ILLEGAL_TRAP_EN
      gen_instr(7'b0110011, 1'b0, 0, 0);
`endif
      while (q.size() > 0) begin
         cyc_t c = q.pop_front();
         opcode_i = c.op; zero_i = c.z; mem_ready_i = c.r; #1;
         checks++;
         if (obs !== c.e) begin
            failures++;
            $display("FAIL illegal cyc%0d got=%b exp=%b", n, obs, c.e);
         end
         n++;
         @(negedge clk_i);
      end
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) begin
         mem_ready_i = 1'($urandom_range(0,1)); opcode_i = 7'($urandom); #1;
         checks++;
         if (obs !== v(0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,1)) begin
            failures++;
            $display("FAIL halt_hold cyc%0d got=%b exp=%b", i, obs,
                     v(0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,1));
         end
         @(negedge clk_i);
      end
      rst_i = 1'b1; #1;
      @(negedge clk_i);
      rst_i = 1'b0; mem_ready_i = 1'b0; #1;
      checks++;
      if (obs !== v(0,0,0,0,1,0,0, 2'd0, 2'd0, 2'd1, 2'd0, 0,0)) begin
         failures++;
         $display("FAIL halt_reset_to_fetch got=%b", obs);
      end
      @(negedge clk_i);
`endif
   endtask

   initial begin
      test_reset();
      test_add();
      test_load_wait();
      test_branch();
      test_jalr();
      test_reset_mid_store();
      test_back_to_back();
      test_illegal();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
